scan_controller: RTL and testbench



---
 rtl/sudoku_pkg.sv | 38 +++
 rtl/grid_classifier.sv | 28 ++
 rtl/scan_controller.sv | 141 ++++++++++++++
 tb/tb_scan_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared types for the sudoku candidate-scan solver.
// Purely declarative: no latency, no flow control.
// Used by scan_controller and grid_classifier.
package sudoku_pkg;

    localparam int N_DIGITS = 9;

    // Bit n set means digit n+1 is still a candidate for the cell.
    typedef logic [N_DIGITS-1:0] cand_t;

    // Working grid, indexed [x][y].
    typedef cand_t [8:0][8:0] grid_t;

    // Scanner result, indexed [bx][by][k]; k walks the box row-major.
    typedef cand_t [2:0][2:0][8:0] box_grid_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        CAPTURE,
        CHECK,
        DONE
    } ctrl_state_e;

    typedef enum logic [1:0] {
        STATUS_SOLVED        = 2'd0,
        STATUS_STALLED       = 2'd1,
        STATUS_CONTRADICTION = 2'd2,
        STATUS_TIMEOUT       = 2'd3
    } solve_status_e;

    // True when exactly one candidate remains.
    function automatic logic is_onehot(input cand_t v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/grid_classifier.sv
// Classifies a candidate grid: any empty cell, or every cell resolved.
// Latency: purely combinational.
// Backpressure: none; outputs follow the grid input directly.
// Ports: grid (in, working grid), any_zero (out), all_onehot (out).
module grid_classifier
    import sudoku_pkg::*;
(
    input  grid_t grid,
    output logic  any_zero,
    output logic  all_onehot
);

    always_comb begin
        any_zero   = 1'b0;
        all_onehot = 1'b1;
        for (int x = 0; x < 9; x++) begin
            for (int y = 0; y < 9; y++) begin
                if (grid[x][y] == '0) begin
                    any_zero = 1'b1;
                end
                if (!is_onehot(grid[x][y])) begin
                    all_onehot = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/scan_controller.sv
// Iterates an external candidate scanner over a working sudoku grid until solved/stuck.
// Latency: 1 load cycle, then SCAN_LATENCY+2 cycles per iteration, then 1 done cycle.
// Backpressure: none; i_Start is only honoured in IDLE, o_Done is a single-cycle pulse.
// Ports: i_Clk/i_Rst_n clock and async reset; i_Start/i_Grid load a puzzle;
// o_Scan_Grid/i_Scan_Grid form the scanner loop (i_Scan_Complete is informational);
// o_Busy, o_Done, o_Status, o_Iter, o_Grid report progress and the result.
module scan_controller
    import sudoku_pkg::*;
#(
    parameter int SCAN_LATENCY = 2,
    parameter int MAX_ITER     = 64
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Start,
    input  grid_t      i_Grid,
    output grid_t      o_Scan_Grid,
    input  box_grid_t  i_Scan_Grid,
    input  logic       i_Scan_Complete,
    output logic       o_Busy,
    output logic       o_Done,
    output logic [1:0] o_Status,
    output logic [6:0] o_Iter,
    output grid_t      o_Grid
);

    localparam int               CNT_W      = (SCAN_LATENCY > 1) ? $clog2(SCAN_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_LATENCY - 1);
    localparam logic [6:0]       ITER_LIMIT = 7'(MAX_ITER);

    ctrl_state_e   state_q, state_d;
    solve_status_e outcome;
    grid_t         work_q;
    grid_t         mapped;
    grid_t         captured;
    logic [CNT_W-1:0] cnt_q;
    logic [6:0]    iter_q;
    logic [1:0]    status_q;
    logic          changed_q;
    logic          changed;
    logic          any_zero;
    logic          all_onehot;

    // The scanner completion flag carries no information the fixed
    // SCAN_LATENCY count does not already give us.
    logic unused_scan_complete;
    assign unused_scan_complete = i_Scan_Complete;

    grid_classifier u_classifier (
        .grid       (work_q),
        .any_zero   (any_zero),
        .all_onehot (all_onehot)
    );

    // Box k walks columns fastest: k%3 is the x offset, k/3 the y offset.
    always_comb begin
        mapped = '0;
        for (int bx = 0; bx < 3; bx++) begin
            for (int by = 0; by < 3; by++) begin
                for (int k = 0; k < 9; k++) begin
                    mapped[3*bx + k%3][3*by + k/3] = i_Scan_Grid[bx][by][k];
                end
            end
        end
    end

    // ANDing keeps the grid monotone: a scanner can never add a candidate back.
    assign captured = work_q & mapped;
    assign changed  = (captured != work_q);

    always_comb begin
        state_d = state_q;
        outcome = STATUS_SOLVED;
        case (state_q)
            IDLE:    if (i_Start) state_d = LOAD;
            LOAD:    state_d = SCAN;
            SCAN:    if (cnt_q == CNT_LAST) state_d = CAPTURE;
            CAPTURE: state_d = CHECK;
            CHECK: begin
                state_d = DONE;
                if (any_zero) begin
                    outcome = STATUS_CONTRADICTION;
                end else if (all_onehot) begin
                    outcome = STATUS_SOLVED;
                end else if (!changed_q) begin
                    outcome = STATUS_STALLED;
                end else if (iter_q == ITER_LIMIT) begin
                    outcome = STATUS_TIMEOUT;
                end else begin
                    state_d = SCAN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            iter_q    <= '0;
            status_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    work_q <= i_Grid;
                    iter_q <= '0;
                    cnt_q  <= '0;
                end
                SCAN: begin
                    // Wraps to zero on exit so the next iteration starts clean.
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                end
                CAPTURE: begin
                    work_q    <= captured;
                    changed_q <= changed;
                    iter_q    <= (iter_q == 7'h7F) ? iter_q : iter_q + 7'd1;
                end
                CHECK: begin
                    if (state_d == DONE) begin
                        status_q <= outcome;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_Scan_Grid = work_q;
    assign o_Grid      = work_q;
    assign o_Busy      = (state_q == LOAD) || (state_q == SCAN) ||
                         (state_q == CAPTURE) || (state_q == CHECK);
    assign o_Done      = (state_q == DONE);
    assign o_Status    = status_q;
    assign o_Iter      = iter_q;

endmodule

// File: tb/tb_scan_controller.sv
// Directed bench for scan_controller with a delayed golden scanner model.
// Two instances: the default MAX_ITER one, and MAX_ITER=3 for timeout.
// Each scenario task drives stimulus and checks its own results inline.
module tb_scan_controller;
    import sudoku_pkg::*;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start2;
    logic       scan_complete;
    grid_t      grid_in, grid_in2;
    grid_t      scan_grid, scan_grid2, out_grid, out_grid2;
    box_grid_t  scan_res, scan_res2;
    logic       busy, done, busy2, done2;
    logic [1:0] status, status2;
    logic [6:0] iter, iter2;
    int         mode;
    box_grid_t  pipe  [L];
    box_grid_t  pipe2 [L];
    grid_t      sol_g, puzzle;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    scan_controller #(.SCAN_LATENCY(L)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Grid(grid_in),
        .o_Scan_Grid(scan_grid), .i_Scan_Grid(scan_res), .i_Scan_Complete(scan_complete),
        .o_Busy(busy), .o_Done(done), .o_Status(status), .o_Iter(iter), .o_Grid(out_grid)
    );

    scan_controller #(.SCAN_LATENCY(L), .MAX_ITER(3)) dut2 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start2), .i_Grid(grid_in2),
        .o_Scan_Grid(scan_grid2), .i_Scan_Grid(scan_res2), .i_Scan_Complete(scan_complete),
        .o_Busy(busy2), .o_Done(done2), .o_Status(status2), .o_Iter(iter2), .o_Grid(out_grid2)
    );

    // Golden single-candidate eliminator: drop every digit already fixed in a peer.
    function automatic grid_t elim(input grid_t g);
        grid_t r;
        cand_t m;
        for (int x = 0; x < 9; x++) begin
            for (int y = 0; y < 9; y++) begin
                m = '0;
                for (int px = 0; px < 9; px++) begin
                    for (int py = 0; py < 9; py++) begin
                        if (!(px == x && py == y) &&
                            (px == x || py == y || (px/3 == x/3 && py/3 == y/3)) &&
                            is_onehot(g[px][py]))
                            m = m | g[px][py];
                    end
                end
                r[x][y] = g[x][y] & ~m;
            end
        end
        return r;
    endfunction

    function automatic box_grid_t to_box(input grid_t g);
        box_grid_t b;
        for (int bx = 0; bx < 3; bx++)
            for (int by = 0; by < 3; by++)
                for (int k = 0; k < 9; k++)
                    b[bx][by][k] = g[3*bx + k%3][3*by + k/3];
        return b;
    endfunction

    // 0: eliminator, 1: identity, 2: drop lowest candidate, 3: single-bit mapping probe.
    function automatic box_grid_t scan_fn(input int m, input grid_t g);
        grid_t     t;
        box_grid_t b;
        case (m)
            0: b = to_box(elim(g));
            1: b = to_box(g);
            2: begin
                for (int x = 0; x < 9; x++)
                    for (int y = 0; y < 9; y++)
                        t[x][y] = g[x][y] & (g[x][y] - 9'd1);
                b = to_box(t);
            end
            default: begin
                b = '1;
                b[2][1][5][0] = 1'b0;
            end
        endcase
        return b;
    endfunction

    function automatic bit solves(input grid_t g0, input grid_t target);
        grid_t g, n;
        g = g0;
        for (int i = 0; i < 60; i++) begin
            n = elim(g);
            if (n == g) break;
            g = n;
        end
        return g == target;
    endfunction

    function automatic int count_diff(input grid_t a, input grid_t b);
        int c = 0;
        for (int x = 0; x < 9; x++)
            for (int y = 0; y < 9; y++)
                if (a[x][y] !== b[x][y]) c++;
        return c;
    endfunction

    always @(posedge clk) begin
        pipe[0]  <= scan_fn(mode, scan_grid);
        pipe2[0] <= scan_fn(2, scan_grid2);
        for (int i = 1; i < L; i++) begin
            pipe[i]  <= pipe[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign scan_res  = pipe[L-1];
    assign scan_res2 = pipe2[L-1];

    // Pulses start on the next edge and counts edges until o_Done is seen.
    task automatic run_solve(input grid_t g, input int budget, output int cycles, output bit seen);
        @(posedge clk); #1;
        grid_in = g;
        start   = 1'b1;
        cycles  = 0;
        seen    = 1'b0;
        while (cycles < budget && !seen) begin
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 0;
        grid_in = '1; grid_in2 = '1; scan_complete = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (status !== 2'd0) begin n_fail++; $display("FAIL reset_status got %0d want 0", status); end
        n_checks++; if (iter !== 7'd0) begin n_fail++; $display("FAIL reset_iter got %0d want 0", iter); end
        n_checks++; if (count_diff(out_grid, '0) != 0) begin n_fail++; $display("FAIL reset_grid %0d nonzero cells want 0", count_diff(out_grid, '0)); end
        rst_n = 1'b1;
    endtask

    task automatic test_easy_solve();
        int cycles; bit seen;
        mode = 0;
        run_solve(puzzle, 2000, cycles, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL easy_done no o_Done within %0d cycles", cycles); end
        n_checks++; if (status !== 2'd0) begin n_fail++; $display("FAIL easy_status got %0d want 0", status); end
        n_checks++; if (count_diff(out_grid, sol_g) != 0) begin n_fail++; $display("FAIL easy_grid %0d cells differ from solution want 0", count_diff(out_grid, sol_g)); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL easy_done_width got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL easy_busy_after got %b want 0", busy); end
    endtask

    task automatic test_contradiction();
        int cycles; bit seen; grid_t g;
        mode = 0;
        g = '1; g[4][4] = '0;
        run_solve(g, 200, cycles, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL contra_done no o_Done within %0d cycles", cycles); end
        n_checks++; if (cycles != L + 4) begin n_fail++; $display("FAIL contra_latency got %0d want %0d", cycles, L + 4); end
        n_checks++; if (status !== 2'd2) begin n_fail++; $display("FAIL contra_status got %0d want 2", status); end
        n_checks++; if (iter !== 7'd1) begin n_fail++; $display("FAIL contra_iter got %0d want 1", iter); end
    endtask

    task automatic test_stall();
        int cycles; bit seen;
        mode = 1;
        run_solve('1, 200, cycles, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_done no o_Done within %0d cycles", cycles); end
        n_checks++; if (status !== 2'd1) begin n_fail++; $display("FAIL stall_status got %0d want 1", status); end
        n_checks++; if (iter !== 7'd1) begin n_fail++; $display("FAIL stall_iter got %0d want 1", iter); end
    endtask

    task automatic test_timeout();
        int cycles = 0; bit seen = 1'b0; grid_t exp_g;
        for (int x = 0; x < 9; x++) for (int y = 0; y < 9; y++) exp_g[x][y] = 9'h1F8;
        @(posedge clk); #1;
        grid_in2 = '1;
        start2   = 1'b1;
        while (cycles < 200 && !seen) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            cycles++;
            if (done2) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL timeout_done no o_Done within %0d cycles", cycles); end
        n_checks++; if (status2 !== 2'd3) begin n_fail++; $display("FAIL timeout_status got %0d want 3", status2); end
        n_checks++; if (iter2 !== 7'd3) begin n_fail++; $display("FAIL timeout_iter got %0d want 3", iter2); end
        n_checks++; if (count_diff(out_grid2, exp_g) != 0) begin n_fail++; $display("FAIL timeout_grid %0d cells differ from 1F8 want 0", count_diff(out_grid2, exp_g)); end
    endtask

    task automatic test_start_ignored();
        int cycles = 0; bit seen = 1'b0; grid_t bad;
        mode = 3;
        bad = '1; bad[0][0] = '0;
        @(posedge clk); #1;
        grid_in = '1;
        start   = 1'b1;
        while (cycles < 200 && !seen) begin
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
            // Now in SCAN: a second start with a contradictory grid must be ignored.
            if (cycles == 2) begin
                start   = 1'b1;
                grid_in = bad;
            end
            if (done) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL restart_done no o_Done within %0d cycles", cycles); end
        n_checks++; if (cycles != 2*L + 6) begin n_fail++; $display("FAIL restart_latency got %0d want %0d", cycles, 2*L + 6); end
        n_checks++; if (status !== 2'd1) begin n_fail++; $display("FAIL restart_status got %0d want 1", status); end
        n_checks++; if (iter !== 7'd2) begin n_fail++; $display("FAIL restart_iter got %0d want 2", iter); end
    endtask

    task automatic test_reset_mid_solve();
        int cycles = 0; bit seen = 1'b0; bit stray_done = 1'b0; grid_t exp_g;
        mode = 3;
        exp_g = '1; exp_g[8][4] = 9'h1FE;
        @(posedge clk); #1;
        grid_in = '1;
        start   = 1'b1;
        // Edge L+5 after the start sample lands in the second iteration's SCAN.
        repeat (L + 5) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_checks++; if (busy !== 1'b1 || iter !== 7'd1) begin n_fail++; $display("FAIL midsolve_pre busy=%b iter=%0d want busy=1 iter=1", busy, iter); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        n_checks++; if (status !== 2'd0) begin n_fail++; $display("FAIL abort_status got %0d want 0", status); end
        n_checks++; if (iter !== 7'd0) begin n_fail++; $display("FAIL abort_iter got %0d want 0", iter); end
        n_checks++; if (count_diff(out_grid, '0) != 0) begin n_fail++; $display("FAIL abort_grid %0d nonzero cells want 0", count_diff(out_grid, '0)); end
        repeat (4) begin
            @(posedge clk); #1;
            if (done) stray_done = 1'b1;
        end
        n_checks++; if (stray_done) begin n_fail++; $display("FAIL abort_no_done got pulse want none"); end
        // Release and start together: the very next edge must take the start.
        rst_n = 1'b1;
        start = 1'b1;
        while (cycles < 200 && !seen) begin
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
            if (done) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL fresh_done no o_Done within %0d cycles", cycles); end
        n_checks++; if (cycles != 2*L + 6) begin n_fail++; $display("FAIL fresh_latency got %0d want %0d", cycles, 2*L + 6); end
        n_checks++; if (status !== 2'd1) begin n_fail++; $display("FAIL fresh_status got %0d want 1", status); end
        n_checks++; if (iter !== 7'd2) begin n_fail++; $display("FAIL fresh_iter got %0d want 2", iter); end
        n_checks++; if (count_diff(out_grid, exp_g) != 0) begin n_fail++; $display("FAIL mapping_grid %0d cells differ want 0, cell[8][4]=%h want 1fe", count_diff(out_grid, exp_g), out_grid[8][4]); end
    endtask

    initial begin
        int blanks = 0;
        int idx;
        grid_t trial;
        // Valid solution: row y is the base row shifted by 3*(y%3) + y/3.
        for (int x = 0; x < 9; x++)
            for (int y = 0; y < 9; y++)
                sol_g[x][y] = cand_t'(1) << ((3*(y%3) + y/3 + x) % 9);
        // Blank cells greedily while the eliminator alone still reaches the solution.
        puzzle = sol_g;
        for (int i = 0; i < 81 && blanks < 51; i++) begin
            idx   = (i * 29) % 81;
            trial = puzzle;
            trial[idx % 9][idx / 9] = 9'h1FF;
            if (solves(trial, sol_g)) begin
                puzzle = trial;
                blanks++;
            end
        end

        test_reset();
        test_easy_solve();
        test_contradiction();
        test_stall();
        test_timeout();
        test_start_ignored();
        test_reset_mid_solve();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
